// File: rtl/spi_arb_pkg.sv
// Shared sizing defaults and FSM encoding for the SPI transmit arbiter.
package spi_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 12;
    localparam int TIMEOUT = 1023;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;
endpackage

// File: rtl/spi_rr_picker.sv
// Rotating-priority encoder: first set req bit at or above ptr, wrapping.
module spi_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               vld,
    output logic [ID_W-1:0]    idx
);
    int j;

    // Scan from farthest to nearest so the closest set bit to ptr wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        j   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                vld = 1'b1;
                idx = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI transmitter among NUM_REQ requesters,
// with spi_done edge detection and a per-transfer timeout abort.
module spi_tx_arbiter #(
    parameter int NUM_REQ = spi_arb_pkg::NUM_REQ,
    parameter int DATA_W  = spi_arb_pkg::DATA_W,
    parameter int TIMEOUT = spi_arb_pkg::TIMEOUT,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      err,
    output logic [ID_W-1:0]           err_id,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_din,
    input  logic                      spi_done
);
    import spi_arb_pkg::*;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, idx_q, pick_idx;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q, rise, pick_vld;
    logic              take, fin_ok, fin_to;

    spi_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign rise = spi_done & ~done_q;
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        fin_ok  = 1'b0;
        fin_to  = 1'b0;
        case (state_q)
            IDLE: if (pick_vld) begin
                state_d = XFER;
                take    = 1'b1;
            end
            // A rise on the timeout cycle takes priority and counts as success.
            XFER: if (rise) begin
                state_d = ACK;
                fin_ok  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ACK;
                fin_to  = 1'b1;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            spi_start <= 1'b0;
            spi_din   <= '0;
            grant     <= '0;
            ack       <= '0;
            err       <= 1'b0;
            err_id    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= spi_done;
            ack     <= '0;
            err     <= 1'b0;
            if (take) begin
                idx_q     <= pick_idx;
                grant     <= NUM_REQ'(1) << pick_idx;
                spi_din   <= req_data[pick_idx*DATA_W +: DATA_W];
                cnt_q     <= '0;
                spi_start <= 1'b1;
            end else if (state_q == XFER) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fin_ok || fin_to) begin
                spi_start <= 1'b0;
                grant     <= '0;
                ptr_q     <= (idx_q == ID_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            if (fin_ok) ack <= NUM_REQ'(1) << idx_q;
            if (fin_to) begin
                err    <= 1'b1;
                err_id <= idx_q;
            end
        end
    end
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench: two arbiters (default timeout and TIMEOUT=16) sharing clk/rst/req_data.
module tb_spi_tx_arbiter;
    typedef struct packed {
        logic [3:0]  ack;
        logic        err;
        logic [1:0]  id;
        logic [11:0] din;
    } ev_t;

    logic        clk = 0, rst = 1;
    logic [47:0] req_data = '0;
    logic [3:0]  req_a = '0, req_b = '0;
    logic        done_a = 0, done_b = 0;
    logic [3:0]  a_ack, a_grant, b_ack, b_grant;
    logic        a_busy, a_err, a_start, b_busy, b_err, b_start;
    logic [1:0]  a_err_id, b_err_id;
    logic [11:0] a_din, b_din;

    int checks = 0, errors = 0;
    ev_t qa[$], qb[$];
    ev_t ea, eb;
    int low_cnt = 0;
    bit seen_hi = 0;

    spi_tx_arbiter #(.NUM_REQ(4), .DATA_W(12)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_data(req_data), .ack(a_ack),
        .grant(a_grant), .busy(a_busy), .err(a_err), .err_id(a_err_id),
        .spi_start(a_start), .spi_din(a_din), .spi_done(done_a));

    spi_tx_arbiter #(.NUM_REQ(4), .DATA_W(12), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_data(req_data), .ack(b_ack),
        .grant(b_grant), .busy(b_busy), .err(b_err), .err_id(b_err_id),
        .spi_start(b_start), .spi_din(b_din), .spi_done(done_b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ev_t mk(logic [3:0] a, logic e, logic [1:0] id, logic [11:0] d);
        ev_t r;
        r.ack = a; r.err = e; r.id = id; r.din = d;
        return r;
    endfunction

    task automatic set_data(input logic [11:0] d0, d1, d2, d3);
        req_data = {d3, d2, d1, d0};
    endtask

    task automatic wait_start_a(output int t);
        t = 0;
        while (!a_start && t < 50) begin @(negedge clk); t++; end
        if (!a_start) chk("a_start_wait", {31'd0, a_start}, 1);
    endtask

    task automatic wait_start_b(output int t);
        t = 0;
        while (!b_start && t < 50) begin @(negedge clk); t++; end
        if (!b_start) chk("b_start_wait", {31'd0, b_start}, 1);
    endtask

    // Wait for start, then raise done n edges later; optionally drop req with it.
    task automatic serve_a(input int n, input bit drop);
        int t;
        wait_start_a(t);
        repeat (n) @(posedge clk);
        #1 done_a = 1;
        if (drop) req_a = '0;
        @(posedge clk);
        #1 done_a = 0;
    endtask

    // Scoreboard monitors: every ack/err pulse must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (a_ack != 0 || a_err)) begin
            if (qa.size() == 0) chk("a_unexpected_event", {27'd0, a_ack, a_err}, 0);
            else begin
                ea = qa.pop_front();
                chk("a_ack", a_ack, ea.ack);
                chk("a_err", a_err, ea.err);
                if (ea.err) chk("a_err_id", a_err_id, ea.id);
                chk("a_din", a_din, ea.din);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (b_ack != 0 || b_err)) begin
            if (qb.size() == 0) chk("b_unexpected_event", {27'd0, b_ack, b_err}, 0);
            else begin
                eb = qb.pop_front();
                chk("b_ack", b_ack, eb.ack);
                chk("b_err", b_err, eb.err);
                if (eb.err) chk("b_err_id", b_err_id, eb.id);
                chk("b_din", b_din, eb.din);
            end
        end
    end

    // spi_start must stay low at least two cycles between transfers.
    always @(negedge clk) begin
        if (rst) begin
            seen_hi = 0;
            low_cnt = 0;
        end else if (a_start) begin
            if (seen_hi && low_cnt > 0) begin
                checks++;
                if (low_cnt < 2) begin
                    errors++;
                    $display("FAIL start_gap: low %0d cycles, required >= 2", low_cnt);
                end
            end
            seen_hi = 1;
            low_cnt = 0;
        end else low_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_outputs", {a_ack, a_grant, a_busy, a_err, a_err_id, a_start, a_din}, 0);
        chk("rst_b_outputs", {b_ack, b_grant, b_busy, b_err, b_err_id, b_start, b_din}, 0);
        rst = 0;

        // Fairness: all four held from ptr=0 -> 0,1,2,3,0.
        @(posedge clk); #1;
        set_data(12'h100, 12'h101, 12'h102, 12'h103);
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) qa.push_back(mk(4'b0001 << (k % 4), 0, 0, 12'h100 + 12'(k % 4)));
        for (int k = 0; k < 5; k++) serve_a(3, k == 4);
        repeat (4) @(negedge clk);
        chk("fair_idle_busy", {31'd0, a_busy}, 0);

        // Single request: latency, data, grant, ack once, busy falls after ACK.
        @(posedge clk); #1;
        set_data(12'h0A5, 12'h111, 12'h222, 12'h333);
        req_a = 4'b0001;
        qa.push_back(mk(4'b0001, 0, 0, 12'h0A5));
        @(negedge clk);
        chk("single_no_start_yet", {31'd0, a_start}, 0);
        @(negedge clk);
        chk("single_start", {31'd0, a_start}, 1);
        chk("single_grant", a_grant, 4'b0001);
        chk("single_din", a_din, 12'h0A5);
        chk("single_busy", {31'd0, a_busy}, 1);
        serve_a(30, 1);
        @(negedge clk);
        chk("single_busy_in_ack", {31'd0, a_busy}, 1);
        @(negedge clk);
        chk("single_busy_fell", {31'd0, a_busy}, 0);

        // done rise while idle is ignored.
        @(posedge clk); #1 done_a = 1;
        repeat (2) @(posedge clk); #1 done_a = 0;
        @(negedge clk);
        chk("idle_done_busy", {31'd0, a_busy}, 0);
        chk("idle_done_grant", a_grant, 0);

        // Reset mid-XFER (ptr=1 beforehand, so requester 0 proves ptr was cleared).
        @(posedge clk); #1;
        set_data(12'h100, 12'h101, 12'h102, 12'h103);
        req_a = 4'b0100;
        wait_start_a(t);
        chk("rstmid_grant", a_grant, 4'b0100);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("rstmid_a_outputs", {a_ack, a_grant, a_busy, a_err, a_err_id, a_start, a_din}, 0);
        @(posedge clk); #1;
        rst = 0;
        req_a = 4'b0011;
        qa.push_back(mk(4'b0001, 0, 0, 12'h100));
        wait_start_a(t);
        chk("rstmid_latency", t, 2);
        chk("rstmid_regrant", a_grant, 4'b0001);
        serve_a(3, 1);

        // Timeout on TIMEOUT=16 instance: err 16 cycles after start, then requester 3.
        @(posedge clk); #1;
        req_b = 4'b1100;
        qb.push_back(mk(4'b0000, 1, 2, 12'h102));
        qb.push_back(mk(4'b1000, 0, 0, 12'h103));
        wait_start_b(t);
        chk("to_grant", b_grant, 4'b0100);
        t = 0;
        while (!b_err && t < 40) begin @(negedge clk); t++; end
        chk("to_latency", t, 16);
        chk("to_no_ack", b_ack, 0);
        wait_start_b(t);
        chk("to_next_grant", b_grant, 4'b1000);
        chk("to_err_id_held", b_err_id, 2);
        @(posedge clk); #1 done_b = 1; req_b = '0;
        @(posedge clk); #1 done_b = 0;
        repeat (3) @(negedge clk);

        // Race: done rise on the timeout cycle wins; data change after grant is ignored.
        @(posedge clk); #1;
        set_data(12'h100, 12'h0C3, 12'h102, 12'h103);
        req_b = 4'b0010;
        qb.push_back(mk(4'b0010, 0, 0, 12'h0C3));
        wait_start_b(t);
        chk("race_grant", b_grant, 4'b0010);
        @(posedge clk); #1 req_data = {48{1'b1}};
        repeat (14) @(posedge clk);
        #1 done_b = 1; req_b = '0;
        @(posedge clk); #1 done_b = 0;
        @(negedge clk);
        chk("race_busy_ack", {31'd0, b_busy}, 1);

        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin @(negedge clk); t++; end
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
